complex_mul_real_pipe: RTL and testbench

COMPLEX_MUL_REAL_PIPE -- requirements
Module: complex_mul_real_pipe

---
 rtl/complex_mul_real_pipe.sv | 160 ++++++++++++++++
 tb/tb_complex_mul_real_pipe.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/complex_mul_real_pipe.sv
// Complex-by-real multiplier with round/shift/saturate and an elastic valid/ready pipeline.
// Each sample carries the coefficient captured when it was accepted.
module complex_mul_real_pipe #(
    parameter int WL     = 14,
    parameter int WL_C   = 14,
    parameter int WL_OUT = 14,
    parameter int SHIFT  = 12,
    parameter int RND    = 1,
    parameter int PIPE   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [WL-1:0]     ar,
    input  logic signed [WL-1:0]     ai,
    input  logic                     coef_ld,
    input  logic signed [WL_C-1:0]   coef_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [WL_OUT-1:0] cr,
    output logic signed [WL_OUT-1:0] ci,
    output logic                     sat,
    output logic                     sat_sticky,
    input  logic                     sat_clr
);

    localparam int PW = WL + WL_C;
    localparam int IW = PW + 1;
    localparam int NR = (PIPE > 1) ? PIPE - 1 : 1;

    localparam logic signed [IW-1:0] RND_ADD =
        (RND != 0 && SHIFT > 0) ? (IW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [IW-1:0] SAT_MAX =
        {{(IW - WL_OUT + 1){1'b0}}, {(WL_OUT - 1){1'b1}}};
    localparam logic signed [IW-1:0] SAT_MIN = ~SAT_MAX;

    // One guard bit above the product keeps the rounding add from wrapping.
    function automatic logic signed [IW-1:0] round_shift(input logic signed [PW-1:0] prod);
        logic signed [IW-1:0] ext;
        ext = IW'(prod);
        ext = ext + RND_ADD;
        return ext >>> SHIFT;
    endfunction

    // MSB of the result flags clipping; lower WL_OUT bits are the value.
    function automatic logic [WL_OUT:0] saturate(input logic signed [IW-1:0] v);
        if (v > SAT_MAX)
            return {1'b1, SAT_MAX[WL_OUT-1:0]};
        else if (v < SAT_MIN)
            return {1'b1, SAT_MIN[WL_OUT-1:0]};
        else
            return {1'b0, v[WL_OUT-1:0]};
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic signed [WL_C-1:0] coef_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coef_q <= '0;
        else if (coef_ld)
            coef_q <= coef_in;
    end

    logic signed [WL-1:0]   src_ar, src_ai;
    logic signed [WL_C-1:0] src_coef;
    logic                   src_vld;

    generate
        if (PIPE > 1) begin : g_in_reg
            logic signed [WL-1:0]   ar_p0, ai_p0;
            logic signed [WL_C-1:0] coef_p0;
            logic                   vld_p0;

            // Stage p0: capture operands together with the coefficient in force now.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ar_p0   <= '0;
                    ai_p0   <= '0;
                    coef_p0 <= '0;
                    vld_p0  <= 1'b0;
                end else if (adv) begin
                    ar_p0   <= ar;
                    ai_p0   <= ai;
                    coef_p0 <= coef_q;
                    vld_p0  <= in_valid;
                end
            end

            assign src_ar   = ar_p0;
            assign src_ai   = ai_p0;
            assign src_coef = coef_p0;
            assign src_vld  = vld_p0;
        end else begin : g_in_comb
            assign src_ar   = ar;
            assign src_ai   = ai;
            assign src_coef = coef_q;
            assign src_vld  = in_valid;
        end
    endgenerate

    logic signed [PW-1:0] prod_r, prod_i;
    logic signed [IW-1:0] sh_r, sh_i;
    logic [WL_OUT:0]      q_r, q_i;

    assign prod_r = PW'(src_ar) * PW'(src_coef);
    assign prod_i = PW'(src_ai) * PW'(src_coef);
    assign sh_r   = round_shift(prod_r);
    assign sh_i   = round_shift(prod_i);
    assign q_r    = saturate(sh_r);
    assign q_i    = saturate(sh_i);

    logic signed [WL_OUT-1:0] cr_p [NR];
    logic signed [WL_OUT-1:0] ci_p [NR];
    logic                     sat_p [NR];
    logic                     vld_p [NR];

    // Result stages: quantised value enters slot 0, last slot drives the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) begin
                cr_p[i]  <= '0;
                ci_p[i]  <= '0;
                sat_p[i] <= 1'b0;
                vld_p[i] <= 1'b0;
            end
        end else if (adv) begin
            cr_p[0]  <= q_r[WL_OUT-1:0];
            ci_p[0]  <= q_i[WL_OUT-1:0];
            sat_p[0] <= src_vld && (q_r[WL_OUT] || q_i[WL_OUT]);
            vld_p[0] <= src_vld;
            for (int i = 1; i < NR; i++) begin
                cr_p[i]  <= cr_p[i-1];
                ci_p[i]  <= ci_p[i-1];
                sat_p[i] <= sat_p[i-1];
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign out_valid = vld_p[NR-1];
    assign cr        = cr_p[NR-1];
    assign ci        = ci_p[NR-1];
    assign sat       = sat_p[NR-1];

    // Set wins over clear so a clip seen on the clearing edge is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_sticky <= 1'b0;
        else if (out_valid && out_ready && sat)
            sat_sticky <= 1'b1;
        else if (sat_clr)
            sat_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_complex_mul_real_pipe.sv
// Directed bench for complex_mul_real_pipe at default parameters, with a truncating
// twin instance sharing the same inputs.
module tb_complex_mul_real_pipe;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, out_ready, coef_ld, sat_clr;
    logic signed [13:0] ar, ai, coef_in;

    logic in_ready, out_valid, sat, sat_sticky;
    logic signed [13:0] cr, ci;
    logic t_in_ready, t_out_valid, t_sat, t_sat_sticky;
    logic signed [13:0] t_cr, t_ci;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    complex_mul_real_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .ar(ar), .ai(ai), .coef_ld(coef_ld), .coef_in(coef_in),
        .out_valid(out_valid), .out_ready(out_ready), .cr(cr), .ci(ci),
        .sat(sat), .sat_sticky(sat_sticky), .sat_clr(sat_clr)
    );

    complex_mul_real_pipe #(.RND(0)) dut_trunc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
        .ar(ar), .ai(ai), .coef_ld(coef_ld), .coef_in(coef_in),
        .out_valid(t_out_valid), .out_ready(out_ready), .cr(t_cr), .ci(t_ci),
        .sat(t_sat), .sat_sticky(t_sat_sticky), .sat_clr(sat_clr)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coef(input int v);
        coef_ld = 1'b1;
        coef_in = 14'(v);
        tick();
        coef_ld = 1'b0;
    endtask

    task automatic run_one(input string tag, input int a_r, input int a_i,
                           input int e_cr, input int e_ci, input int e_sat,
                           input int e_tcr, input int e_tci);
        ar = 14'(a_r);
        ai = 14'(a_i);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, ".vld_early"}, int'(out_valid), 0);
        tick();
        check({tag, ".vld"}, int'(out_valid), 1);
        check({tag, ".cr"}, int'(cr), e_cr);
        check({tag, ".ci"}, int'(ci), e_ci);
        check({tag, ".sat"}, int'(sat), e_sat);
        check({tag, ".trunc_cr"}, int'(t_cr), e_tcr);
        check({tag, ".trunc_ci"}, int'(t_ci), e_tci);
    endtask

    initial begin
        int sent, recv, budget;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; coef_ld = 1'b0;
        sat_clr = 1'b0; ar = '0; ai = '0; coef_in = '0;
        #1;
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.cr", int'(cr), 0);
        check("rst.ci", int'(ci), 0);
        check("rst.sat", int'(sat), 0);
        check("rst.in_ready", int'(in_ready), 1);
        check("rst.sat_sticky", int'(sat_sticky), 0);
        tick(); tick();
        rst_n = 1'b1;

        load_coef(2048);
        run_one("basic", 4096, -4096, 2048, -2048, 0, 2048, -2048);
        run_one("round", 3, -3, 2, -1, 0, 1, -2);

        load_coef(-8192);
        run_one("satur", -8192, 8191, 8191, -8192, 1, 8191, -8192);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sticky.set_beats_clr", int'(sat_sticky), 1);
        check("sticky.sat_idle", int'(sat), 0);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sticky.cleared", int'(sat_sticky), 0);

        load_coef(2048);
        ar = 14'(4096); ai = '0; in_valid = 1'b1;
        coef_ld = 1'b1; coef_in = 14'(1024);
        tick();
        coef_ld = 1'b0;
        tick();
        in_valid = 1'b0;
        check("coefswap.first_vld", int'(out_valid), 1);
        check("coefswap.first_cr", int'(cr), 2048);
        tick();
        check("coefswap.second_vld", int'(out_valid), 1);
        check("coefswap.second_cr", int'(cr), 1024);
        tick();

        load_coef(4096);
        sent = 1; recv = 1;
        for (int cyc = 0; cyc < 120 && sent <= 40; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            ar = 14'(sent); ai = 14'(-sent); in_valid = 1'b1;
            #1;
            check("bp.in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                check("bp.cr", int'(cr), recv);
                check("bp.ci", int'(ci), -recv);
                recv++;
            end
            if (in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (recv < sent && budget < 20) begin
            #1;
            if (out_valid) begin
                check("bp.drain_cr", int'(cr), recv);
                recv++;
            end
            @(posedge clk); #1;
            budget++;
        end
        check("bp.count", recv, sent);
        check("bp.empty", int'(out_valid), 0);

        load_coef(2048);
        ar = 14'(4096); ai = 14'(-4096); in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        check("rstmid.inflight", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rstmid.vld_async", int'(out_valid), 0);
        check("rstmid.cr_async", int'(cr), 0);
        #1;
        rst_n = 1'b1;
        tick();
        check("rstmid.no_stale", int'(out_valid), 0);
        tick();
        check("rstmid.no_stale2", int'(out_valid), 0);
        run_one("rstcoef", 4096, -4096, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
